hc_enc: RTL and testbench

Streaming Hamming(7,4) encoder; transmit-side counterpart to the team's `hc_dec` single-error-correcting decoder. Accepts multi-nibble data words over a valid/ready handshake. Splits each word into 4-bit nibbles and emits one registered 7-bit codeword per nibble downstream. The codeword bit layout is the exact one `hc_dec` consumes.

---
 rtl/hc_enc.sv | 110 +++++++++++
 tb/tb_hc_enc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hc_enc.sv
// hc_enc: streaming Hamming(7,4) encoder, one registered codeword per input nibble, LSB nibble first.
// Optional build macro HC_ERR_INJ_EN adds per-codeword single-bit error injection ports.
// Revision: 1.0
`default_nettype none

module hc_enc #(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3,
  parameter int NIBS    = 2,
  parameter int CNT_WD  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DATA_WD*NIBS:1]       i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [DATA_WD+CHK_WD:1]     o_enc_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic [CNT_WD-1:0]           o_cw_cnt
`ifdef HC_ERR_INJ_EN
  ,
  input  logic                        i_inj_en,
  input  logic [3:1]                  i_inj_pos
`endif
);

  localparam int CW_WD  = DATA_WD + CHK_WD;
  localparam int IDX_WD = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(NIBS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [DATA_WD*NIBS-1:0]   word;
  logic [DATA_WD*NIBS-1:0]   word_shift;
  logic [IDX_WD-1:0]         nib_idx;
  logic [IDX_WD-1:0]         nib_idx_nxt;
  logic [CW_WD:1]            inj_mask;
  logic                      in_xfer;
  logic                      out_xfer;

  function automatic logic [CW_WD:1] encode(input logic [DATA_WD-1:0] d);
    logic [CW_WD:1] c;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

`ifdef HC_ERR_INJ_EN
  always_comb begin
    inj_mask = '0;
    if (i_inj_en && (i_inj_pos != 3'd0))
      inj_mask[i_inj_pos] = 1'b1;
  end
`else
  assign inj_mask = '0;
`endif

  // o_last is only ever set while BUSY, so it doubles as "presenting the final nibble".
  assign o_ready     = !i_rst && ((state == IDLE) || (o_last && i_ready));
  assign in_xfer     = i_valid && o_ready;
  assign out_xfer    = o_valid && i_ready;
  assign word_shift  = word >> DATA_WD;
  assign nib_idx_nxt = nib_idx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      word       <= '0;
      nib_idx    <= '0;
      o_valid    <= 1'b0;
      o_enc_data <= '0;
      o_last     <= 1'b0;
      o_cw_cnt   <= '0;
    end else begin
      if (out_xfer)
        o_cw_cnt <= o_cw_cnt + 1'b1;
      // A new word takes priority; it also covers the back-to-back case on the final nibble.
      if (in_xfer) begin
        state      <= BUSY;
        word       <= i_data;
        nib_idx    <= '0;
        o_valid    <= 1'b1;
        o_enc_data <= encode(i_data[DATA_WD:1]) ^ inj_mask;
        o_last     <= (NIBS == 1);
      end else if (out_xfer) begin
        if (!o_last) begin
          word       <= word_shift;
          nib_idx    <= nib_idx_nxt;
          o_enc_data <= encode(word_shift[DATA_WD-1:0]) ^ inj_mask;
          o_last     <= (nib_idx_nxt == LAST_IDX);
        end else begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hc_enc.sv
// tb_hc_enc: directed plus randomized check of hc_enc against a queue-based reference model.
`default_nettype none

module tb_hc_enc;

  localparam int NIBS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [4*NIBS-1:0] data;
  logic              valid;
  logic              ready_in;
  logic              ready_out;
  logic [7:1]        enc;
  logic              out_valid;
  logic              last;
  logic [15:0]       cw_cnt;
  logic              inj_en;
  logic [3:1]        inj_pos;

  int vectors = 0;
  int errors  = 0;

  logic [6:0]  q_cw[$];
  bit          q_last[$];
  logic [6:0]  cur;
  logic [15:0] exp_cnt;
  bit          armed = 0;
  bit          clean = 0;

  hc_enc #(.DATA_WD(4), .CHK_WD(3), .NIBS(NIBS), .CNT_WD(16)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_data(data),
    .i_valid(valid),
    .o_ready(ready_out),
    .o_enc_data(enc),
    .o_valid(out_valid),
    .i_ready(ready_in),
    .o_last(last),
    .o_cw_cnt(cw_cnt)
`ifdef HC_ERR_INJ_EN
    ,
    .i_inj_en(inj_en),
    .i_inj_pos(inj_pos)
`endif
  );

  always #5 clk = ~clk;

  // Generic Hamming rule: data fills non-power-of-two positions in order,
  // parity position p covers every other position whose index has bit p set.
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [6:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 4; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int q = 1; q <= 7; q++)
        if (((q & p) != 0) && (q != p)) par = par ^ c[q-1];
      c[p-1] = par;
    end
    return c;
  endfunction

  function automatic logic [6:0] cur_mask();
    logic [6:0] m;
    m = '0;
`ifdef HC_ERR_INJ_EN
    if (inj_en && inj_pos != 3'd0) m = 7'(1) << (int'(inj_pos) - 1);
`endif
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [6:0] cw, input logic lst);
    check("directed_cw", 32'(enc), 32'(cw));
    check("directed_last", 32'(last), 32'(lst));
  endtask

  // One clock: compare against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit exp_valid, exp_ready, in_x, out_x, loaded;
    #1;
    exp_valid = (q_cw.size() != 0);
    exp_ready = !rst && ((q_cw.size() == 0) || (ready_in && q_cw.size() == 1));
    if (armed) begin
      check("ready", 32'(ready_out), 32'(exp_ready));
      check("valid", 32'(out_valid), 32'(exp_valid));
      check("cw_cnt", 32'(cw_cnt), 32'(exp_cnt));
      check("last", 32'(last), 32'(exp_valid && q_last[0]));
      if (exp_valid) check("enc", 32'(enc), 32'(cur));
      else if (clean) check("enc_reset", 32'(enc), 32'h0);
    end
    in_x  = !rst && valid && exp_ready;
    out_x = !rst && exp_valid && ready_in;
    @(posedge clk);
    if (rst) begin
      q_cw.delete();
      q_last.delete();
      exp_cnt = '0;
      clean   = 1;
      armed   = 1;
    end else begin
      loaded = 0;
      if (out_x) begin
        void'(q_cw.pop_front());
        void'(q_last.pop_front());
        exp_cnt = exp_cnt + 16'd1;
        if (q_cw.size() != 0) loaded = 1;
      end
      if (in_x) begin
        for (int n = 0; n < NIBS; n++) begin
          q_cw.push_back(ref_enc(data[4*n +: 4]));
          q_last.push_back(n == NIBS - 1);
        end
        loaded = 1;
      end
      if (loaded) begin
        cur   = q_cw[0] ^ cur_mask();
        clean = 0;
      end
    end
    #1;
  endtask

  initial begin
    exp_cnt  = '0;
    cur      = '0;
    inj_en   = 1'b0;
    inj_pos  = 3'd0;
    rst      = 1'b1;
    valid    = 1'b1;
    data     = 8'hFB;
    ready_in = 1'b1;
    repeat (3) cycle();
    check("reset_enc", 32'(enc), 32'h0);
    check("reset_cnt", 32'(cw_cnt), 32'h0);

    // Basic encode of 0xFB
    rst = 1'b0;
    cycle();
    valid = 1'b0;
    expect_out(7'h55, 1'b0);
    cycle();
    expect_out(7'h7F, 1'b1);
    cycle();
    check("cnt_after_fb", 32'(cw_cnt), 32'd2);

    // Backpressure on 0xF0
    valid = 1'b1; data = 8'hF0; ready_in = 1'b0;
    cycle();
    valid = 1'b0;
    repeat (5) begin
      expect_out(7'h00, 1'b0);
      cycle();
    end
    ready_in = 1'b1;
    expect_out(7'h00, 1'b0);
    cycle();
    expect_out(7'h7F, 1'b1);
    cycle();
    cycle();

    // Back-to-back words 0x0B then 0xB0
    valid = 1'b1; data = 8'h0B;
    cycle();
    data = 8'hB0;
    expect_out(7'h55, 1'b0);
    cycle();
    expect_out(7'h00, 1'b1);
    cycle();
    valid = 1'b0;
    expect_out(7'h00, 1'b0);
    cycle();
    expect_out(7'h55, 1'b1);
    cycle();
    cycle();

    // Reset while the first nibble of 0xFB is presented
    valid = 1'b1; data = 8'hFB;
    cycle();
    valid = 1'b0; rst = 1'b1;
    expect_out(7'h55, 1'b0);
    cycle();
    rst = 1'b0;
    check("midreset_valid", 32'(out_valid), 32'h0);
    check("midreset_cnt", 32'(cw_cnt), 32'h0);
    cycle();
    cycle();

`ifdef HC_ERR_INJ_EN
    inj_en = 1'b1; inj_pos = 3'd3; valid = 1'b1; data = 8'h0B;
    cycle();
    inj_en = 1'b0; valid = 1'b0;
    expect_out(7'h51, 1'b0);
    cycle();
    cycle();
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      valid    = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      data     = 8'($urandom);
`ifdef HC_ERR_INJ_EN
      inj_en   = ($urandom_range(0, 3) == 0);
      inj_pos  = 3'($urandom);
`endif
      cycle();
    end
    rst = 1'b0; valid = 1'b0; ready_in = 1'b1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
